rx_serial_param: RTL and testbench
==================================

# rx_serial_param

Parametrised UART receiver: oversampled start-bit detection, configurable data width, runtime parity mode, one or two stop bits, and full error reporting (parity, framing, overrun). It combines control unit and datapath in a single block. It sits between the asynchronous RX pin and the consumer logic, and presents a held data word with a `valid`/`ack` handshake plus a one-cycle `pronto` pulse.

## Interface
- `DATA_BITS`, default 7: data bits per frame, LSB first; legal range 5–9.
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be even and ≥ 4.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clock` — input, 1 bit: clock.
- `reset` — input, 1 bit: reset, asynchronous, active-high.
- `RX` — input, 1 bit: serial line; idle high; asynchronous to `clock`.
- `parity_mode` — input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none. Sampled only in IDLE.
- `ack` — input, 1 bit: consumer has taken `dados`; clears `valid`.
- `dados` — output, `DATA_BITS` bits: last received word, held until the next completed frame.
- `valid` — output, 1 bit: a word is waiting in `dados`.
- `pronto` — output, 1 bit: one-cycle pulse on frame completion, whether the frame was good or bad.
- `erro_paridade` — output, 1 bit: parity error of the last frame.
- `erro_frame` — output, 1 bit: a stop bit was sampled low.
- `overrun` — output, 1 bit: sticky; a frame completed while `valid` was 1.
- `db_estado` — output, 4 bits: state code, for debug.

## Operation
- `RX` passes through a 2-flop synchroniser, `rx_s`; all logic uses `rx_s` only.
- States and `db_estado` codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5; an illegal state shows 4'hE and recovers to IDLE.
- IDLE → START: `rx_s` is 0. Clear the bit-time counter, latch `parity_mode`.
- START: at counter value `CLKS_PER_BIT/2 - 1` (mid start bit):
  - `rx_s` = 1 → glitch; return to IDLE with no outputs changed.
  - `rx_s` = 0 → go to DATA and clear the counter.
- DATA: sample `rx_s` every `CLKS_PER_BIT` cycles (mid bit) and shift it in LSB first.
  - After `DATA_BITS` samples: go to PARITY if the mode is even or odd, otherwise to STOP.
- PARITY: one mid-bit sample.
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if XOR(data, parity bit) = 0.
- STOP: `STOP_BITS` mid-bit samples; any low sample sets the frame-error flag.
- DONE, one cycle, then IDLE:
  - Load `dados`.
  - Load `erro_paridade` and `erro_frame`.
  - Pulse `pronto`.
  - Set `valid`.
  - If `valid` was already 1 and `ack` is not asserted this cycle, set `overrun`.
- IDLE after DONE waits for `rx_s` = 1 before arming again. A line held low (break) therefore yields exactly one frame, with a framing error.
- `ack`:
  - Clears `valid` and `overrun` on the next edge.
  - When `ack` and DONE occur in the same cycle, DONE wins: `valid` stays 1 and `overrun` is not set.
- Error flags stay valid until the next DONE.
- Frames with errors are still delivered (`valid` = 1); the consumer checks the flags.

## Timing
- Reset values: every output 0; `dados` = 0; state IDLE; `overrun` = 0; synchroniser flops = 1.
- Let E be the first cycle in which `rx_s` = 0 in IDLE. Sample points:
  - Start bit: cycle E + `CLKS_PER_BIT/2`.
  - Data bit i: start sample + (i+1)·`CLKS_PER_BIT`.
  - Parity and stop bits follow at the same pitch.
- `pronto` is high in the cycle after the last stop sample. `dados`, `valid` and the error flags change on the same edge that raises `pronto`.
- Example, 7E1 with `CLKS_PER_BIT` = 16: the stop bit is sampled at E+152 and `pronto` is high at E+153.
- Pin-to-E latency: 2–3 cycles (synchroniser).
- `reset` mid-frame: immediately returns to IDLE and clears every output; the partial frame is discarded.

## Structure
- Shared include file `rx_serial_defs.vh` holds:
  - state codes;
  - `parity_mode` encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - `db_estado` codes, for reuse by the matching TX block.
- One natural sub-module: `rx_bit_timer`. It is a `CLKS_PER_BIT` counter with `zera` input and `meio` (mid-bit) pulse output.
- Shift register, bit counter and flags stay in the top module.

## Test plan
1. 7E1, `CLKS_PER_BIT` = 16, send 0x41 with parity bit 0:
   - `dados` = 7'h41 and `pronto` pulses at E+153.
   - `erro_paridade` = 0, `erro_frame` = 0, `valid` = 1.
2. Same settings, flip the parity bit to 1: `dados` = 7'h41, `erro_paridade` = 1, `pronto` pulses.
3. `RX` low pulse of 5 cycles then high: no `pronto`; state returns to IDLE (`db_estado` = 0) by E+9.
4. Two back-to-back frames 0x12 then 0x34 with no `ack`: `dados` = 0x34, `overrun` = 1. A later `ack` clears both `valid` and `overrun`.
5. `DATA_BITS` = 8, `STOP_BITS` = 2, no parity, second stop bit low:
   - `erro_frame` = 1 and the data word is delivered.
   - Then `RX` held low for 30 bit times yields exactly one `pronto`.
6. Assert `reset` during DATA bit 3: all outputs return to 0 immediately. The next clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/rx_serial_param_pkg.sv
// Shared definitions for the UART receiver: state encoding, parity modes and
// debug state codes, kept here so the matching TX block can reuse them.
package rx_serial_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [3:0] DB_IDLE    = 4'h0;
  localparam logic [3:0] DB_START   = 4'h1;
  localparam logic [3:0] DB_DATA    = 4'h2;
  localparam logic [3:0] DB_PARITY  = 4'h3;
  localparam logic [3:0] DB_STOP    = 4'h4;
  localparam logic [3:0] DB_DONE    = 4'h5;
  localparam logic [3:0] DB_ILLEGAL = 4'hE;

  function automatic logic [3:0] db_code(input state_t s);
    case (s)
      ST_IDLE:   db_code = DB_IDLE;
      ST_START:  db_code = DB_START;
      ST_DATA:   db_code = DB_DATA;
      ST_PARITY: db_code = DB_PARITY;
      ST_STOP:   db_code = DB_STOP;
      ST_DONE:   db_code = DB_DONE;
      default:   db_code = DB_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter: free-running modulo CLKS_PER_BIT, cleared by zera;
// meio pulses one cycle at the middle of each bit period.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  output logic meio
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (zera || cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign meio = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));

endmodule

// File: rtl/rx_serial_param.sv
// UART receiver: synchronised RX, mid-bit sampling, optional parity, 1-2 stop bits,
// held output word with valid/ack handshake, pronto pulse and sticky overrun.
module rx_serial_param #(
  parameter int DATA_BITS    = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  input  logic [1:0]           parity_mode,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] dados,
  output logic                 valid,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_frame,
  output logic                 overrun,
  output logic [3:0]           db_estado
);

  import rx_serial_param_pkg::*;

  logic                 rx_meta_q, rx_s_q;
  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] dados_q, dados_d;
  logic                 valid_q, valid_d;
  logic                 erro_paridade_q, erro_paridade_d;
  logic                 erro_frame_q, erro_frame_d;
  logic                 overrun_q, overrun_d;
  logic                 zera, meio, load, parity_on;

  // The counter is cleared only on the start edge; its wrap keeps meio on the
  // mid-bit phase for every following bit of the frame.
  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .meio  (meio)
  );

  assign parity_on = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    armed_d         = armed_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    par_err_d       = par_err_q;
    frame_err_d     = frame_err_q;
    dados_d         = dados_q;
    valid_d         = valid_q;
    erro_paridade_d = erro_paridade_q;
    erro_frame_d    = erro_frame_q;
    overrun_d       = overrun_q;
    zera            = 1'b0;
    load            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        zera = 1'b1;
        if (!armed_q) begin
          armed_d = rx_s_q;
        end else if (!rx_s_q) begin
          state_d = ST_START;
          mode_d  = parity_mode;
        end
      end
      ST_START: begin
        if (meio) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DATA;
            bit_cnt_d   = '0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (meio) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = parity_on ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (meio) begin
          par_err_d = (^shift_q) ^ rx_s_q ^ (mode_q == PAR_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (meio) begin
          frame_err_d = frame_err_q | ~rx_s_q;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            load    = 1'b1;
            armed_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completing frame takes priority over a simultaneous ack.
    if (load) begin
      dados_d         = shift_q;
      erro_paridade_d = par_err_q;
      erro_frame_d    = frame_err_q | ~rx_s_q;
      valid_d         = 1'b1;
      if (valid_q && !ack) begin
        overrun_d = 1'b1;
      end else if (ack) begin
        overrun_d = 1'b0;
      end
    end else if (ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= ST_IDLE;
      mode_q          <= PAR_NONE;
      armed_q         <= 1'b1;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      dados_q         <= '0;
      valid_q         <= 1'b0;
      erro_paridade_q <= 1'b0;
      erro_frame_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      rx_meta_q       <= RX;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      mode_q          <= mode_d;
      armed_q         <= armed_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      par_err_q       <= par_err_d;
      frame_err_q     <= frame_err_d;
      dados_q         <= dados_d;
      valid_q         <= valid_d;
      erro_paridade_q <= erro_paridade_d;
      erro_frame_q    <= erro_frame_d;
      overrun_q       <= overrun_d;
    end
  end

  assign dados         = dados_q;
  assign valid         = valid_q;
  assign pronto        = (state_q == ST_DONE);
  assign erro_paridade = erro_paridade_q;
  assign erro_frame    = erro_frame_q;
  assign overrun       = overrun_q;
  assign db_estado     = db_code(state_q);

endmodule

// File: tb/tb_rx_serial_param.sv
// Directed bench for rx_serial_param: a 7E1 instance and an 8N2 instance.
module tb_rx_serial_param;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       rx0, rx1, ack0, ack1;
  logic [1:0] pm0, pm1;
  logic [6:0] dados0;
  logic [7:0] dados1;
  logic       valid0, pronto0, ep0, ef0, ov0;
  logic       valid1, pronto1, ep1, ef1, ov1;
  logic [3:0] db0, db1;

  int cyc = 0;
  int np0 = 0, np1 = 0, last0 = 0, last1 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pronto0 === 1'b1) begin np0++; last0 = cyc; end
    if (pronto1 === 1'b1) begin np1++; last1 = cyc; end
  end

  rx_serial_param #(.DATA_BITS(7), .CLKS_PER_BIT(16), .STOP_BITS(1)) u0 (
    .clock(clk), .reset(rst0), .RX(rx0), .parity_mode(pm0), .ack(ack0),
    .dados(dados0), .valid(valid0), .pronto(pronto0), .erro_paridade(ep0),
    .erro_frame(ef0), .overrun(ov0), .db_estado(db0));

  rx_serial_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .STOP_BITS(2)) u1 (
    .clock(clk), .reset(rst1), .RX(rx1), .parity_mode(pm1), .ack(ack1),
    .dados(dados1), .valid(valid1), .pronto(pronto1), .erro_paridade(ep1),
    .erro_frame(ef1), .overrun(ov1), .db_estado(db1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives frame bits LSB first, 16 cycles each, then leaves the line idle high.
  task automatic send(input int u, input logic [31:0] frame, input int n, output int n0);
    @(posedge clk); #1;
    n0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (u == 0) rx0 = frame[i]; else rx1 = frame[i];
      repeat (16) @(posedge clk);
      #1;
    end
    if (u == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ack0();
    @(posedge clk); #1 ack0 = 1'b1;
    @(posedge clk); #1 ack0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0, p0, p1;
    logic [31:0] fr;
    rst0 = 1'b1; rst1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    ack0 = 1'b0; ack1 = 1'b0; pm0 = 2'b01; pm1 = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dados", 32'(dados0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_pronto", 32'(pronto0), 0);
    check("rst_flags", {29'd0, ep0, ef0, ov0}, 0);
    check("rst_db", 32'(db0), 0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (10) @(posedge clk);

    // 1: 7E1 0x41, parity 0
    p0 = np0;
    send(0, {22'd0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, n0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t1_npronto", np0 - p0, 1);
    check("t1_pronto_cyc", last0 - n0, 155);
    check("t1_dados", 32'(dados0), 32'h41);
    check("t1_perr", 32'(ep0), 0);
    check("t1_ferr", 32'(ef0), 0);
    check("t1_valid", 32'(valid0), 1);
    pulse_ack0();
    check("t1_ack_valid", 32'(valid0), 0);

    // 2: parity bit flipped
    p0 = np0;
    send(0, {22'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, n0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_npronto", np0 - p0, 1);
    check("t2_dados", 32'(dados0), 32'h41);
    check("t2_perr", 32'(ep0), 1);
    pulse_ack0();

    // 3: 5-cycle glitch
    repeat (5) @(posedge clk);
    p0 = np0;
    @(posedge clk); #1;
    n0 = cyc;
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx0 = 1'b1;
    wait_cyc(n0 + 7);
    check("t3_db_start", 32'(db0), 1);
    wait_cyc(n0 + 11);
    check("t3_db_idle", 32'(db0), 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t3_npronto", np0 - p0, 0);

    // 4: back-to-back 0x12 (p=0) and 0x34 (p=1), no ack
    p0 = np0;
    fr = {12'd0, 1'b1, 1'b1, 7'h34, 1'b0, 1'b1, 1'b0, 7'h12, 1'b0};
    send(0, fr, 20, n0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_npronto", np0 - p0, 2);
    check("t4_pronto_cyc", last0 - n0, 315);
    check("t4_dados", 32'(dados0), 32'h34);
    check("t4_perr", 32'(ep0), 0);
    check("t4_overrun", 32'(ov0), 1);
    check("t4_valid", 32'(valid0), 1);
    pulse_ack0();
    check("t4_ack_valid", 32'(valid0), 0);
    check("t4_ack_overrun", 32'(ov0), 0);

    // 5: 8N2, second stop low, then a 30-bit break
    p1 = np1;
    send(1, {21'd0, 1'b0, 1'b1, 8'hA5, 1'b0}, 11, n0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_npronto", np1 - p1, 1);
    check("t5_pronto_cyc", last1 - n0, 171);
    check("t5_dados", 32'(dados1), 32'hA5);
    check("t5_ferr", 32'(ef1), 1);
    check("t5_perr", 32'(ep1), 0);
    check("t5_valid", 32'(valid1), 1);
    p1 = np1;
    @(posedge clk); #1 rx1 = 1'b0;
    repeat (480) @(posedge clk);
    #1 rx1 = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t5_brk_npronto", np1 - p1, 1);
    check("t5_brk_dados", 32'(dados1), 0);
    check("t5_brk_ferr", 32'(ef1), 1);
    check("t5_brk_overrun", 32'(ov1), 1);
    check("t5_brk_db", 32'(db1), 0);

    // 6: reset during data bit 3, then a clean 0x55
    fr = {22'd0, 1'b1, 1'b1, 7'h2A, 1'b0};
    @(posedge clk); #1;
    n0 = cyc;
    for (int k = 0; k < 70; k++) begin
      rx0 = fr[k / 16];
      @(posedge clk);
      #1;
    end
    check("t6_db_data", 32'(db0), 2);
    #2 rst0 = 1'b1;
    #1;
    check("t6_rst_dados", 32'(dados0), 0);
    check("t6_rst_outs", {28'd0, valid0, ep0, ef0, ov0}, 0);
    check("t6_rst_db", 32'(db0), 0);
    rx0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
    repeat (20) @(posedge clk);
    p0 = np0;
    send(0, {22'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, n0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_npronto", np0 - p0, 1);
    check("t6_pronto_cyc", last0 - n0, 155);
    check("t6_dados", 32'(dados0), 32'h55);
    check("t6_flags", {30'd0, ep0, ef0}, 0);
    check("t6_valid", 32'(valid0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
